// File: rtl/alu_dispatch_fsm.sv
// Request dispatcher that issues one ALU operation to one of four functional units
// and returns that unit's result, or a timeout error if the unit never reports done.
module alu_dispatch_fsm #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   opnd_a,
  output logic [WIDTH-1:0]   opnd_b,
  output logic               demux_i,
  output logic [1:0]         demux_s,
  input  logic [3:0]         unit_done,
  input  logic [4*WIDTH-1:0] unit_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic               resp_err,
  output logic [7:0]         err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t                  state, state_n;
  logic [1:0]              op_r;
  logic [3:0]              wait_cnt;
  logic [3:0][WIDTH-1:0]   res_arr;
  logic                    sel_done;
  logic                    cap_req, load_done, load_to;

  assign res_arr  = unit_result;
  assign sel_done = unit_done[op_r];

  assign req_ready  = (state == IDLE);
  assign demux_i    = (state == ISSUE);
  assign demux_s    = op_r;
  assign resp_valid = (state == RESP);

  always_comb begin
    state_n   = state;
    cap_req   = 1'b0;
    load_done = 1'b0;
    load_to   = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        state_n = ISSUE;
        cap_req = 1'b1;
      end
      ISSUE: state_n = WAIT;
      // A done arriving in the final wait cycle takes priority over the timeout.
      WAIT: if (sel_done) begin
        state_n   = RESP;
        load_done = 1'b1;
      end else if (wait_cnt == WAIT_LAST) begin
        state_n = RESP;
        load_to = 1'b1;
      end
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      wait_cnt  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (cap_req) begin
        op_r   <= op;
        opnd_a <= a;
        opnd_b <= b;
      end
      if (state == ISSUE)      wait_cnt <= '0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + 4'd1;
      if (load_done) begin
        resp_data <= res_arr[op_r];
        resp_err  <= 1'b0;
      end
      if (load_to) begin
        resp_data <= '0;
        resp_err  <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch_fsm.sv
// Directed bench for alu_dispatch_fsm: inputs driven and outputs sampled on the falling edge.
module tb_alu_dispatch_fsm;

  localparam int W  = 8;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic [W-1:0]   opnd_a, opnd_b;
  logic           demux_i;
  logic [1:0]     demux_s;
  logic [3:0]     unit_done = '0;
  logic [4*W-1:0] unit_result = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic [7:0]     err_cnt;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  alu_dispatch_fsm #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .a(a), .b(b), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .demux_i(demux_i), .demux_s(demux_s), .unit_done(unit_done),
    .unit_result(unit_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (demux_i === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call from a falling edge with the FSM in IDLE; returns at the falling edge in ISSUE.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_demux_i", demux_i, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_opnd_a", opnd_a, 0);
    rst = 1'b0;

    // basic: op=2, done one cycle after ISSUE
    unit_result[0*W +: W] = 8'h11;
    unit_result[1*W +: W] = 8'h22;
    unit_result[2*W +: W] = 8'h46;
    unit_result[3*W +: W] = 8'h33;
    issue(2'd2, 8'h12, 8'h34);
    check("basic_demux_i", demux_i, 1);
    check("basic_demux_s", demux_s, 2);
    check("basic_opnd_a", opnd_a, 8'h12);
    check("basic_opnd_b", opnd_b, 8'h34);
    check("basic_req_ready", req_ready, 0);
    @(negedge clk);
    unit_done = 4'b0100;
    check("basic_wait_demux_i", demux_i, 0);
    check("basic_wait_valid", resp_valid, 0);
    @(negedge clk);
    unit_done = 4'b0000;
    check("basic_resp_valid", resp_valid, 1);
    check("basic_resp_data", resp_data, 8'h46);
    check("basic_resp_err", resp_err, 0);
    check("basic_pulses", pulses, 1);
    @(negedge clk);
    check("basic_idle_ready", req_ready, 1);
    check("basic_idle_valid", resp_valid, 0);

    // wrong unit: only unit 3 reports done for an op=1 request
    unit_done = 4'b1000;
    issue(2'd1, 8'h01, 8'h02);
    repeat (TO) @(negedge clk);
    check("wrong_no_resp", resp_valid, 0);
    @(negedge clk);
    check("wrong_resp_valid", resp_valid, 1);
    check("wrong_resp_err", resp_err, 1);
    check("wrong_resp_data", resp_data, 0);
    check("wrong_err_cnt", err_cnt, 1);
    unit_done = 4'b0000;
    @(negedge clk);

    // tie: selected done in the timeout cycle, then backpressure
    unit_result[0*W +: W] = 8'hA5;
    issue(2'd0, 8'h55, 8'h66);
    repeat (TO) @(negedge clk);
    check("tie_no_resp", resp_valid, 0);
    unit_done = 4'b0001;
    resp_ready = 1'b0;
    @(negedge clk);
    unit_done = 4'b0000;
    check("tie_resp_valid", resp_valid, 1);
    check("tie_resp_err", resp_err, 0);
    check("tie_resp_data", resp_data, 8'hA5);
    check("tie_err_cnt", err_cnt, 1);
    op = 2'd3; a = 8'h77; b = 8'h88; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_data", resp_data, 8'hA5);
      check("bp_req_ready", req_ready, 0);
    end
    check("bp_pulses", pulses, 3);
    // handshake with req_valid still high: IDLE first, acceptance one cycle later
    resp_ready = 1'b1;
    @(negedge clk);
    check("hs_req_ready", req_ready, 1);
    check("hs_demux_i", demux_i, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("hs_issue_demux_i", demux_i, 1);
    check("hs_issue_demux_s", demux_s, 3);
    check("hs_issue_opnd_a", opnd_a, 8'h77);

    // reset mid-WAIT
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_demux_s", demux_s, 0);
    check("mid_rst_opnd_a", opnd_a, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_valid", resp_valid, 0);
    issue(2'd3, 8'h09, 8'h0A);
    @(negedge clk);
    unit_done = 4'b1000;
    @(negedge clk);
    unit_done = 4'b0000;
    check("post_rst_resp_valid", resp_valid, 1);
    check("post_rst_resp_data", resp_data, 8'h33);
    check("post_rst_resp_err", resp_err, 0);
    @(negedge clk);

    // saturation: 257 back-to-back timeouts
    for (int n = 1; n <= 257; n++) begin
      issue(2'd2, 8'h00, 8'h00);
      for (int k = 0; k < 40 && resp_valid !== 1'b1; k++) @(negedge clk);
      check("sat_resp_valid", resp_valid, 1);
      if (n == 254) check("sat_err_cnt_254", err_cnt, 254);
      if (n == 256) check("sat_err_cnt_256", err_cnt, 255);
      if (n == 257) check("sat_err_cnt_257", err_cnt, 255);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
